// File: rtl/tcdm_port_arbiter_if.sv
// tcdm_port_arbiter_if
//   Bundles the requester-side and TCDM-master-side signals of the
//   arbiter. The "slave" modport is the arbiter's view, the "master"
//   modport is the view of whatever drives requests and the memory side.
//   Requester signals: req_i, add_i, wen_i, be_i, data_i, gnt_o,
//                      r_valid_o, r_data_o (flat vectors, slice k = requester k)
//   TCDM master side:  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o,
//                      tcdm_data_o, tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i
//   Status:            err_o (sticky orphan-response flag)
interface tcdm_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] add_i;
  logic [NUM_REQ-1:0]            wen_i;
  logic [NUM_REQ*BE_WIDTH-1:0]   be_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            r_valid_o;
  logic [DATA_WIDTH-1:0]         r_data_o;

  logic                          tcdm_req_o;
  logic [ADDR_WIDTH-1:0]         tcdm_add_o;
  logic                          tcdm_wen_o;
  logic [BE_WIDTH-1:0]           tcdm_be_o;
  logic [DATA_WIDTH-1:0]         tcdm_data_o;
  logic                          tcdm_gnt_i;
  logic                          tcdm_r_valid_i;
  logic [DATA_WIDTH-1:0]         tcdm_r_data_i;

  logic                          err_o;

  modport slave (
    input  req_i, add_i, wen_i, be_i, data_i,
    input  tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i,
    output gnt_o, r_valid_o, r_data_o,
    output tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    output err_o
  );

  modport master (
    output req_i, add_i, wen_i, be_i, data_i,
    output tcdm_gnt_i, tcdm_r_valid_i, tcdm_r_data_i,
    input  gnt_o, r_valid_o, r_data_o,
    input  tcdm_req_o, tcdm_add_o, tcdm_wen_o, tcdm_be_o, tcdm_data_o,
    input  err_o
  );
endinterface

// File: rtl/tcdm_port_arbiter.sv
// tcdm_port_arbiter
//   Round-robin arbiter folding NUM_REQ requesters onto one TCDM master
//   port. Grants are combinational (no added request latency). Once a
//   request is presented but not granted, the selection is frozen until
//   the handshake. Up to MAX_OUTSTANDING granted transactions are tracked
//   in an ID FIFO so that responses are routed back in order, zero latency.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - tcdm_port_arbiter_if.slave (requester + TCDM master signals)
module tcdm_port_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  tcdm_port_arbiter_if.slave   bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ARB, HOLD} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, sel_q, arb_sel, sel, cand;
  logic             any_req, found, issue_ok, req_out, hs, push, pop;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [IDW-1:0]   id_fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0]   head;
  logic             err_q;
  int               idx;

  logic [NUM_REQ-1:0]    gnt, r_valid;
  logic [ADDR_WIDTH-1:0] m_add;
  logic                  m_wen;
  logic [BE_WIDTH-1:0]   m_be;
  logic [DATA_WIDTH-1:0] m_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Circular search starting one past the last granted requester.
  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
    cand    = '0;
    idx     = 0;
    any_req = |bus.req_i;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && bus.req_i[cand]) begin
        arb_sel = cand;
        found   = 1'b1;
      end
    end
  end

  // A full tracker may still issue when a response frees a slot this cycle.
  assign issue_ok = (cnt_q < CW'(MAX_OUTSTANDING)) ||
                    ((cnt_q == CW'(MAX_OUTSTANDING)) && bus.tcdm_r_valid_i);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:  if (req_out && !bus.tcdm_gnt_i) state_d = HOLD;
      HOLD: if (hs)                         state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // FSM: outputs. In HOLD the presented request is frozen; it only drops
  // while issue is blocked.
  always_comb begin
    sel     = arb_sel;
    req_out = 1'b0;
    case (state_q)
      ARB: begin
        sel     = arb_sel;
        req_out = any_req && issue_ok;
      end
      HOLD: begin
        sel     = sel_q;
        req_out = issue_ok;
      end
      default: ;
    endcase
    if (rst) req_out = 1'b0;
  end

  assign hs = req_out && bus.tcdm_gnt_i;

  // sel_q tracks the free selection while in ARB, so entering HOLD
  // freezes exactly what was presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= IDW'(NUM_REQ - 1);
      sel_q    <= '0;
    end else begin
      if (state_q == ARB) sel_q    <= arb_sel;
      if (hs)             rr_ptr_q <= sel;
    end
  end

  // Request mux and grant decode; master outputs are zero when idle.
  always_comb begin
    m_add  = '0;
    m_wen  = 1'b0;
    m_be   = '0;
    m_data = '0;
    gnt    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_out && (sel == IDW'(k))) begin
        m_add  = bus.add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        m_wen  = bus.wen_i[k];
        m_be   = bus.be_i[k*BE_WIDTH +: BE_WIDTH];
        m_data = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
        gnt[k] = bus.tcdm_gnt_i;
      end
    end
  end

  // Response ID tracking. Responses with nothing outstanding are dropped
  // and flagged instead of popping.
  assign push = hs;
  assign pop  = bus.tcdm_r_valid_i && (cnt_q != '0) && !rst;
  assign head = id_fifo_q[rd_ptr_q];

  always_comb begin
    r_valid = '0;
    for (int k = 0; k < NUM_REQ; k++)
      r_valid[k] = pop && (head == IDW'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (bus.tcdm_r_valid_i && (cnt_q == '0)) err_q <= 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) id_fifo_q[wr_ptr_q] <= sel;
  end

  assign bus.gnt_o       = gnt;
  assign bus.r_valid_o   = r_valid;
  assign bus.r_data_o    = bus.tcdm_r_data_i;
  assign bus.tcdm_req_o  = req_out;
  assign bus.tcdm_add_o  = m_add;
  assign bus.tcdm_wen_o  = m_wen;
  assign bus.tcdm_be_o   = m_be;
  assign bus.tcdm_data_o = m_data;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// tb_tcdm_port_arbiter
//   Directed bench for tcdm_port_arbiter with two requesters and two
//   outstanding slots: a vector table for the round-robin and hold
//   behaviour, then hand-written sequences for the outstanding limit,
//   orphan responses and mid-flight reset.
module tb_tcdm_port_arbiter;
  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  tcdm_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  tcdm_port_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       exp_req;
    logic       exp_sel;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] addr_c [2];
  logic [31:0] data_c [2];
  logic [3:0]  be_c   [2];
  logic [1:0]  wen_c;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [1:0] r, input logic g, input logic v, input logic [31:0] d);
    bus.req_i          = r;
    bus.tcdm_gnt_i     = g;
    bus.tcdm_r_valid_i = v;
    bus.tcdm_r_data_i  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    addr_c[0] = 32'h0000_1000; addr_c[1] = 32'h0000_2000;
    data_c[0] = 32'hAAAA_0000; data_c[1] = 32'hBBBB_1111;
    be_c[0]   = 4'h3;          be_c[1]   = 4'hC;
    wen_c     = 2'b01;

    //          req    gnt   rv    ereq  esel  egnt   erv
    vecs[0]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10};
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01};
    vecs[4]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10};
    // requester 1 alone, grant withheld 3 cycles, requester 0 joins
    vecs[5]  = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00};
    vecs[9]  = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10};
    vecs[10] = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01};

    bus.add_i  = {addr_c[1], addr_c[0]};
    bus.data_i = {data_c[1], data_c[0]};
    bus.be_i   = {be_c[1], be_c[0]};
    bus.wen_i  = wen_c;

    // reset: outputs quiet even with activity on the inputs
    rst = 1'b1;
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(2'b11, 1'b1, 1'b1, 32'h1234);
    chk("rst_tcdm_req", 32'(bus.tcdm_req_o), 32'h0);
    chk("rst_gnt",      32'(bus.gnt_o),      32'h0);
    chk("rst_rvalid",   32'(bus.r_valid_o),  32'h0);
    tick();
    rst = 1'b0;
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rst_err",      32'(bus.err_o),      32'h0);
    chk("idle_add",     bus.tcdm_add_o,      32'h0);
    tick();

    // round robin + hold vectors
    for (int i = 0; i < 11; i++) begin
      logic [31:0] ea, ed;
      logic [3:0]  eb;
      logic        ew;
      set_in(vecs[i].req, vecs[i].gnt, vecs[i].rv, 32'hD000_0000 + 32'(i));
      ea = vecs[i].exp_req ? addr_c[vecs[i].exp_sel] : 32'h0;
      ed = vecs[i].exp_req ? data_c[vecs[i].exp_sel] : 32'h0;
      eb = vecs[i].exp_req ? be_c[vecs[i].exp_sel]   : 4'h0;
      ew = vecs[i].exp_req ? wen_c[vecs[i].exp_sel]  : 1'b0;
      chk($sformatf("v%0d_tcdm_req", i), 32'(bus.tcdm_req_o), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_gnt", i),      32'(bus.gnt_o),      32'(vecs[i].exp_gnt));
      chk($sformatf("v%0d_rvalid", i),   32'(bus.r_valid_o),  32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_add", i),      bus.tcdm_add_o,      ea);
      chk($sformatf("v%0d_data", i),     bus.tcdm_data_o,     ed);
      chk($sformatf("v%0d_be", i),       32'(bus.tcdm_be_o),  32'(eb));
      chk($sformatf("v%0d_wen", i),      32'(bus.tcdm_wen_o), 32'(ew));
      chk($sformatf("v%0d_rdata", i),    bus.r_data_o,        32'hD000_0000 + 32'(i));
      chk($sformatf("v%0d_err", i),      32'(bus.err_o),      32'h0);
      tick();
    end

    // outstanding limit: fill both slots, then block, then issue on a freeing response
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    chk("lim_gnt0", 32'(bus.gnt_o), 32'h1);
    tick();
    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    chk("lim_gnt1", 32'(bus.gnt_o), 32'h2);
    tick();
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    chk("lim_blocked_req", 32'(bus.tcdm_req_o), 32'h0);
    chk("lim_blocked_gnt", 32'(bus.gnt_o),      32'h0);
    chk("lim_blocked_add", bus.tcdm_add_o,      32'h0);
    tick();
    set_in(2'b11, 1'b1, 1'b1, 32'h55);
    chk("lim_refill_req",  32'(bus.tcdm_req_o), 32'h1);
    chk("lim_refill_gnt",  32'(bus.gnt_o),      32'h1);
    chk("lim_refill_rv",   32'(bus.r_valid_o),  32'h1);
    tick();
    set_in(2'b00, 1'b0, 1'b1, 32'h66);
    chk("lim_drain_rv1", 32'(bus.r_valid_o), 32'h2);
    tick();
    set_in(2'b00, 1'b0, 1'b1, 32'h77);
    chk("lim_drain_rv0", 32'(bus.r_valid_o), 32'h1);
    tick();
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    chk("lim_err_clear", 32'(bus.err_o), 32'h0);

    // orphan response with nothing ever requested since reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(2'b00, 1'b0, 1'b1, 32'h99);
    chk("orph_rv",        32'(bus.r_valid_o), 32'h0);
    chk("orph_err_same",  32'(bus.err_o),     32'h0);
    tick();
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    chk("orph_err_next",  32'(bus.err_o),     32'h1);
    tick();
    tick();
    chk("orph_err_stick", 32'(bus.err_o),     32'h1);

    // reset with two in flight
    set_in(2'b01, 1'b1, 1'b0, 32'h0);
    chk("mr_gnt0", 32'(bus.gnt_o), 32'h1);
    tick();
    set_in(2'b10, 1'b1, 1'b0, 32'h0);
    chk("mr_gnt1", 32'(bus.gnt_o), 32'h2);
    tick();
    rst = 1'b1;
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    chk("mr_rst_req", 32'(bus.tcdm_req_o), 32'h0);
    chk("mr_rst_gnt", 32'(bus.gnt_o),      32'h0);
    tick();
    rst = 1'b0;
    set_in(2'b00, 1'b0, 1'b1, 32'hABC);
    chk("mr_err_cleared", 32'(bus.err_o),     32'h0);
    chk("mr_stale_rv",    32'(bus.r_valid_o), 32'h0);
    tick();
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    chk("mr_stale_err", 32'(bus.err_o), 32'h1);
    chk("mr_first_gnt", 32'(bus.gnt_o), 32'h1);
    tick();
    set_in(2'b11, 1'b1, 1'b0, 32'h0);
    chk("mr_second_gnt", 32'(bus.gnt_o), 32'h2);
    tick();
    set_in(2'b00, 1'b0, 1'b0, 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
